// File: rtl/alu_writeback_if.sv
// ALU result handshake into the writeback stage: one result per valid/ready transfer.
interface alu_writeback_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned AW     = 4
);
    logic              in_valid;
    logic              in_ready;
    logic [AW-1:0]     in_rd_idx;
    logic [DATA_W-1:0] in_rd_data;
    logic              in_wr_en;
    logic              in_flag_en;
    logic              in_n;
    logic              in_z;
    logic              in_c;
    logic              in_v;

    modport master (
        output in_valid, in_rd_idx, in_rd_data, in_wr_en, in_flag_en,
               in_n, in_z, in_c, in_v,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_rd_idx, in_rd_data, in_wr_en, in_flag_en,
               in_n, in_z, in_c, in_v,
        output in_ready
    );
endinterface

// File: rtl/alu_writeback.sv
// Retire stage: 2-entry pending-result FIFO feeding the register file, APSR flags and PC load,
// with a bypassed read port and forwarded flags covering results not yet retired.
module alu_writeback #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned NREG   = 16,
    parameter int unsigned AW     = 4,
    parameter int unsigned DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst,
    alu_writeback_if.slave    in_bus,
    input  logic              wb_stall,
    input  logic [AW-1:0]     rd_a_idx,
    output logic [DATA_W-1:0] rd_a_data,
    output logic [3:0]        nzcv_arch,
    output logic [3:0]        nzcv_fwd,
    output logic              pc_load,
    output logic [DATA_W-1:0] pc_value,
    output logic [1:0]        pending
);
    localparam logic [AW-1:0] PC_IDX = AW'(NREG - 1);
    localparam logic [1:0]    FULL   = 2'(DEPTH);

    typedef struct packed {
        logic [AW-1:0]     idx;
        logic [DATA_W-1:0] data;
        logic              wr_en;
        logic              flag_en;
        logic [3:0]        nzcv;
    } entry_t;

    // ent[0] is always the head; ent[1] is only meaningful when pending == 2
    entry_t            ent     [DEPTH];
    entry_t            ent_nxt [DEPTH];
    entry_t            incoming;
    logic [DATA_W-1:0] rf      [NREG-1];
    logic              ready_q;
    logic              push;
    logic              pop;
    logic [1:0]        cnt_nxt;

    assign in_bus.in_ready = ready_q;

    always_comb begin
        incoming.idx     = in_bus.in_rd_idx;
        incoming.data    = in_bus.in_rd_data;
        incoming.wr_en   = in_bus.in_wr_en;
        incoming.flag_en = in_bus.in_flag_en;
        incoming.nzcv    = {in_bus.in_n, in_bus.in_z, in_bus.in_c, in_bus.in_v};
    end

    // FIFO next state: pop shifts the queue down, then a push lands in the first free slot
    always_comb begin
        push    = in_bus.in_valid & ready_q;
        pop     = (pending != 2'd0) & ~wb_stall;
        ent_nxt = ent;
        cnt_nxt = pending;
        if (pop) begin
            ent_nxt[0] = ent[1];
            cnt_nxt    = pending - 2'd1;
        end
        if (push) begin
            ent_nxt[cnt_nxt[0]] = incoming;
            cnt_nxt             = cnt_nxt + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending   <= 2'd0;
            ready_q   <= 1'b1;
            nzcv_arch <= 4'b0000;
            pc_load   <= 1'b0;
            pc_value  <= '0;
            ent[0]    <= '0;
            ent[1]    <= '0;
            rf        <= '{default: '0};
        end else begin
            pending <= cnt_nxt;
            ready_q <= (cnt_nxt != FULL);
            ent     <= ent_nxt;
            pc_load <= 1'b0;
            if (pop) begin
                if (ent[0].wr_en && (ent[0].idx != PC_IDX)) begin
                    rf[ent[0].idx] <= ent[0].data;
                end
                if (ent[0].wr_en && (ent[0].idx == PC_IDX)) begin
                    pc_load  <= 1'b1;
                    pc_value <= ent[0].data;
                end
                if (ent[0].flag_en) begin
                    nzcv_arch <= ent[0].nzcv;
                end
            end
        end
    end

    // Read port: youngest pending writer wins, then older, then the register file
    always_comb begin
        rd_a_data = '0;
        if (rd_a_idx == PC_IDX) begin
            rd_a_data = pc_value;
        end else if ((pending == FULL) && ent[1].wr_en && (ent[1].idx == rd_a_idx)) begin
            rd_a_data = ent[1].data;
        end else if ((pending != 2'd0) && ent[0].wr_en && (ent[0].idx == rd_a_idx)) begin
            rd_a_data = ent[0].data;
        end else begin
            rd_a_data = rf[rd_a_idx];
        end
    end

    always_comb begin
        nzcv_fwd = nzcv_arch;
        if ((pending == FULL) && ent[1].flag_en) begin
            nzcv_fwd = ent[1].nzcv;
        end else if ((pending != 2'd0) && ent[0].flag_en) begin
            nzcv_fwd = ent[0].nzcv;
        end
    end
endmodule

// File: tb/tb_alu_writeback.sv
// Self-checking bench for alu_writeback: directed scenarios plus randomized traffic
// compared against a queue-based reference model of the retire stage.
module tb_alu_writeback;
    logic        clk = 1'b0;
    logic        rst;
    logic        wb_stall;
    logic [3:0]  rd_a_idx;
    logic [31:0] rd_a_data;
    logic [3:0]  nzcv_arch;
    logic [3:0]  nzcv_fwd;
    logic        pc_load;
    logic [31:0] pc_value;
    logic [1:0]  pending;

    always #20 clk = ~clk;

    alu_writeback_if #(.DATA_W(32), .AW(4)) bus ();

    alu_writeback #(.DATA_W(32), .NREG(16), .AW(4), .DEPTH(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_bus    (bus),
        .wb_stall  (wb_stall),
        .rd_a_idx  (rd_a_idx),
        .rd_a_data (rd_a_data),
        .nzcv_arch (nzcv_arch),
        .nzcv_fwd  (nzcv_fwd),
        .pc_load   (pc_load),
        .pc_value  (pc_value),
        .pending   (pending)
    );

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [3:0]  idx;
        logic [31:0] data;
        logic        we;
        logic        fe;
        logic [3:0]  f;
    } m_ent_t;

    // Reference model: in-order queue of pending results plus architectural state
    m_ent_t      m_q [$];
    logic [31:0] m_rf [16];
    logic [3:0]  m_nzcv;
    logic        m_pc_load;
    logic [31:0] m_pc_value;

    function automatic m_ent_t mk(input logic [3:0] idx, input logic [31:0] data,
                                  input logic we, input logic fe, input logic [3:0] f);
        m_ent_t e;
        e.idx = idx; e.data = data; e.we = we; e.fe = fe; e.f = f;
        return e;
    endfunction

    function automatic logic [31:0] m_read(input logic [3:0] idx);
        if (idx == 4'd15) return m_pc_value;
        for (int i = m_q.size() - 1; i >= 0; i--)
            if (m_q[i].we && (m_q[i].idx == idx)) return m_q[i].data;
        return m_rf[idx];
    endfunction

    function automatic logic [3:0] m_fwd();
        for (int i = m_q.size() - 1; i >= 0; i--)
            if (m_q[i].fe) return m_q[i].f;
        return m_nzcv;
    endfunction

    task automatic m_step(input logic r, input logic v, input m_ent_t e, input logic st);
        m_ent_t h;
        bit     ready;
        if (r) begin
            m_q.delete();
            for (int i = 0; i < 16; i++) m_rf[i] = '0;
            m_nzcv = '0; m_pc_load = 1'b0; m_pc_value = '0;
            return;
        end
        ready = (m_q.size() != 2);
        m_pc_load = 1'b0;
        if ((m_q.size() != 0) && !st) begin
            h = m_q.pop_front();
            if (h.we) begin
                if (h.idx == 4'd15) begin
                    m_pc_load = 1'b1;
                    m_pc_value = h.data;
                end else begin
                    m_rf[h.idx] = h.data;
                end
            end
            if (h.fe) m_nzcv = h.f;
        end
        if (v && ready) m_q.push_back(e);
    endtask

    // One clock: drive at negedge, model follows the posedge, outputs settle 1 unit later
    task automatic cycle(input logic r, input logic v, input m_ent_t e, input logic st);
        @(negedge clk);
        rst = r;
        wb_stall = st;
        bus.in_valid = v;
        bus.in_rd_idx = e.idx;
        bus.in_rd_data = e.data;
        bus.in_wr_en = e.we;
        bus.in_flag_en = e.fe;
        {bus.in_n, bus.in_z, bus.in_c, bus.in_v} = e.f;
        @(posedge clk);
        m_step(r, v, e, st);
        #1;
    endtask

    task automatic test_reset();
        cycle(1'b1, 1'b0, mk(0, 0, 0, 0, 0), 1'b0);
        cycle(1'b1, 1'b0, mk(0, 0, 0, 0, 0), 1'b0);
        n_checks++; if (pending !== 2'd0) $display("FAIL reset_pending: got %0d want 0", pending); else n_pass++;
        n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", bus.in_ready); else n_pass++;
        n_checks++; if (nzcv_arch !== 4'b0000) $display("FAIL reset_nzcv: got %b want 0000", nzcv_arch); else n_pass++;
        n_checks++; if (pc_load !== 1'b0) $display("FAIL reset_pc_load: got %b want 0", pc_load); else n_pass++;
        n_checks++; if (pc_value !== 32'h0) $display("FAIL reset_pc_value: got %h want 0", pc_value); else n_pass++;
        for (int i = 0; i < 16; i++) begin
            rd_a_idx = 4'(i);
            #1;
            n_checks++;
            if (rd_a_data !== 32'h0) $display("FAIL reset_rf[%0d]: got %h want 0", i, rd_a_data);
            else n_pass++;
        end
    endtask

    task automatic test_single();
        cycle(1'b0, 1'b1, mk(3, 32'h0000_00F0, 1, 1, 4'b0100), 1'b0);
        cycle(1'b0, 1'b0, mk(0, 0, 0, 0, 0), 1'b0);
        rd_a_idx = 4'd3;
        #1;
        n_checks++; if (rd_a_data !== 32'h0000_00F0) $display("FAIL single_rf3: got %h want 000000f0", rd_a_data); else n_pass++;
        n_checks++; if (nzcv_arch !== 4'b0100) $display("FAIL single_nzcv: got %b want 0100", nzcv_arch); else n_pass++;
        n_checks++; if (pending !== 2'd0) $display("FAIL single_pending: got %0d want 0", pending); else n_pass++;
    endtask

    task automatic test_stall_fill();
        cycle(1'b0, 1'b1, mk(1, 32'hAAAA_0000, 1, 0, 0), 1'b1);
        cycle(1'b0, 1'b1, mk(1, 32'h5555_0000, 1, 0, 0), 1'b1);
        rd_a_idx = 4'd1;
        #1;
        n_checks++; if (pending !== 2'd2) $display("FAIL fill_pending: got %0d want 2", pending); else n_pass++;
        n_checks++; if (bus.in_ready !== 1'b0) $display("FAIL fill_ready: got %b want 0", bus.in_ready); else n_pass++;
        n_checks++; if (rd_a_data !== 32'h5555_0000) $display("FAIL fill_bypass: got %h want 55550000", rd_a_data); else n_pass++;
        cycle(1'b0, 1'b1, mk(2, 32'hDEAD_BEEF, 1, 1, 4'b1111), 1'b1);
        n_checks++; if (pending !== 2'd2) $display("FAIL fill_third_pending: got %0d want 2", pending); else n_pass++;
        n_checks++; if (nzcv_fwd !== 4'b0100) $display("FAIL fill_third_fwd: got %b want 0100", nzcv_fwd); else n_pass++;
        cycle(1'b0, 1'b0, mk(0, 0, 0, 0, 0), 1'b0);
        n_checks++; if (pending !== 2'd1) $display("FAIL fill_retire1: got %0d want 1", pending); else n_pass++;
        cycle(1'b0, 1'b0, mk(0, 0, 0, 0, 0), 1'b0);
        n_checks++; if (pending !== 2'd0) $display("FAIL fill_retire2: got %0d want 0", pending); else n_pass++;
        rd_a_idx = 4'd1;
        #1;
        n_checks++; if (rd_a_data !== 32'h5555_0000) $display("FAIL fill_rf1: got %h want 55550000", rd_a_data); else n_pass++;
        rd_a_idx = 4'd2;
        #1;
        n_checks++; if (rd_a_data !== 32'h0) $display("FAIL fill_dropped_rf2: got %h want 0", rd_a_data); else n_pass++;
    endtask

    task automatic test_flag_fwd();
        cycle(1'b0, 1'b1, mk(0, 32'h1234, 0, 1, 4'b1000), 1'b1);
        cycle(1'b0, 1'b1, mk(4, 32'h5678, 0, 0, 4'b0111), 1'b1);
        cycle(1'b0, 1'b0, mk(0, 0, 0, 0, 0), 1'b1);
        n_checks++; if (nzcv_fwd !== 4'b1000) $display("FAIL fwd_flags: got %b want 1000", nzcv_fwd); else n_pass++;
        n_checks++; if (nzcv_arch !== 4'b0100) $display("FAIL fwd_arch_old: got %b want 0100", nzcv_arch); else n_pass++;
        cycle(1'b0, 1'b0, mk(0, 0, 0, 0, 0), 1'b0);
        cycle(1'b0, 1'b0, mk(0, 0, 0, 0, 0), 1'b0);
        n_checks++; if (nzcv_arch !== 4'b1000) $display("FAIL fwd_arch_new: got %b want 1000", nzcv_arch); else n_pass++;
        rd_a_idx = 4'd4;
        #1;
        n_checks++; if (rd_a_data !== 32'h0) $display("FAIL fwd_no_write: got %h want 0", rd_a_data); else n_pass++;
    endtask

    task automatic test_pc();
        cycle(1'b0, 1'b1, mk(15, 32'h0000_0100, 1, 0, 0), 1'b0);
        n_checks++; if (pc_load !== 1'b0) $display("FAIL pc_early: got %b want 0", pc_load); else n_pass++;
        cycle(1'b0, 1'b0, mk(0, 0, 0, 0, 0), 1'b0);
        n_checks++; if (pc_load !== 1'b1) $display("FAIL pc_pulse: got %b want 1", pc_load); else n_pass++;
        n_checks++; if (pc_value !== 32'h0000_0100) $display("FAIL pc_value: got %h want 00000100", pc_value); else n_pass++;
        cycle(1'b0, 1'b0, mk(0, 0, 0, 0, 0), 1'b0);
        n_checks++; if (pc_load !== 1'b0) $display("FAIL pc_pulse_end: got %b want 0", pc_load); else n_pass++;
        for (int i = 0; i < 16; i++) begin
            rd_a_idx = 4'(i);
            #1;
            n_checks++;
            if (rd_a_data !== m_read(4'(i))) $display("FAIL pc_rf[%0d]: got %h want %h", i, rd_a_data, m_read(4'(i)));
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        cycle(1'b0, 1'b1, mk(5, 32'h1111_1111, 1, 0, 0), 1'b1);
        n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL b2b_ready0: got %b want 1", bus.in_ready); else n_pass++;
        cycle(1'b0, 1'b1, mk(6, 32'h2222_2222, 1, 0, 0), 1'b0);
        n_checks++; if (pending !== 2'd1) $display("FAIL b2b_pending: got %0d want 1", pending); else n_pass++;
        n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL b2b_ready1: got %b want 1", bus.in_ready); else n_pass++;
        rd_a_idx = 4'd5;
        #1;
        n_checks++; if (rd_a_data !== 32'h1111_1111) $display("FAIL b2b_head_retired: got %h want 11111111", rd_a_data); else n_pass++;
        cycle(1'b0, 1'b0, mk(0, 0, 0, 0, 0), 1'b0);
        n_checks++; if (pending !== 2'd0) $display("FAIL b2b_drain: got %0d want 0", pending); else n_pass++;
        n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL b2b_ready2: got %b want 1", bus.in_ready); else n_pass++;
        rd_a_idx = 4'd6;
        #1;
        n_checks++; if (rd_a_data !== 32'h2222_2222) $display("FAIL b2b_second: got %h want 22222222", rd_a_data); else n_pass++;
    endtask

    task automatic test_reset_discard();
        cycle(1'b0, 1'b1, mk(7, 32'hCAFE_F00D, 1, 1, 4'b1010), 1'b1);
        cycle(1'b0, 1'b1, mk(15, 32'h0000_0999, 1, 0, 0), 1'b1);
        cycle(1'b1, 1'b0, mk(0, 0, 0, 0, 0), 1'b1);
        n_checks++; if (pending !== 2'd0) $display("FAIL rst_pending: got %0d want 0", pending); else n_pass++;
        n_checks++; if (nzcv_arch !== 4'b0000) $display("FAIL rst_nzcv: got %b want 0000", nzcv_arch); else n_pass++;
        for (int i = 0; i < 16; i++) begin
            rd_a_idx = 4'(i);
            #1;
            n_checks++;
            if (rd_a_data !== 32'h0) $display("FAIL rst_rf[%0d]: got %h want 0", i, rd_a_data);
            else n_pass++;
        end
        for (int k = 0; k < 3; k++) begin
            cycle(1'b0, 1'b0, mk(0, 0, 0, 0, 0), 1'b0);
            n_checks++; if (pc_load !== 1'b0) $display("FAIL rst_no_pc_load: got %b want 0", pc_load); else n_pass++;
            n_checks++; if (nzcv_arch !== 4'b0000) $display("FAIL rst_no_flags: got %b want 0000", nzcv_arch); else n_pass++;
            rd_a_idx = 4'd7;
            #1;
            n_checks++; if (rd_a_data !== 32'h0) $display("FAIL rst_no_retire: got %h want 0", rd_a_data); else n_pass++;
        end
    endtask

    task automatic test_random();
        m_ent_t      e;
        logic        r, v, st;
        logic [3:0]  ri;
        logic [31:0] exp_rd;
        for (int n = 0; n < 400; n++) begin
            r  = ($urandom_range(0, 63) == 0);
            v  = ($urandom_range(0, 3) != 0);
            st = ($urandom_range(0, 2) == 0);
            e  = mk(4'($urandom_range(0, 15)), $urandom, 1'($urandom), 1'($urandom), 4'($urandom));
            cycle(r, v, e, st);
            n_checks++; if (pending !== 2'(m_q.size())) $display("FAIL rnd_pending @%0d: got %0d want %0d", n, pending, m_q.size()); else n_pass++;
            n_checks++; if (bus.in_ready !== (m_q.size() != 2)) $display("FAIL rnd_ready @%0d: got %b want %b", n, bus.in_ready, m_q.size() != 2); else n_pass++;
            n_checks++; if (nzcv_arch !== m_nzcv) $display("FAIL rnd_nzcv @%0d: got %b want %b", n, nzcv_arch, m_nzcv); else n_pass++;
            n_checks++; if (nzcv_fwd !== m_fwd()) $display("FAIL rnd_fwd @%0d: got %b want %b", n, nzcv_fwd, m_fwd()); else n_pass++;
            n_checks++; if (pc_load !== m_pc_load) $display("FAIL rnd_pc_load @%0d: got %b want %b", n, pc_load, m_pc_load); else n_pass++;
            n_checks++; if (pc_value !== m_pc_value) $display("FAIL rnd_pc_value @%0d: got %h want %h", n, pc_value, m_pc_value); else n_pass++;
            ri = 4'($urandom_range(0, 15));
            rd_a_idx = ri;
            #1;
            exp_rd = m_read(ri);
            n_checks++; if (rd_a_data !== exp_rd) $display("FAIL rnd_rd[%0d] @%0d: got %h want %h", ri, n, rd_a_data, exp_rd); else n_pass++;
        end
    endtask

    initial begin
        rst = 1'b1;
        wb_stall = 1'b0;
        rd_a_idx = 4'd0;
        bus.in_valid = 1'b0;
        bus.in_rd_idx = 4'd0;
        bus.in_rd_data = 32'h0;
        bus.in_wr_en = 1'b0;
        bus.in_flag_en = 1'b0;
        bus.in_n = 1'b0;
        bus.in_z = 1'b0;
        bus.in_c = 1'b0;
        bus.in_v = 1'b0;
        m_step(1'b1, 1'b0, mk(0, 0, 0, 0, 0), 1'b0);
        test_reset();
        test_single();
        test_stall_fill();
        test_flag_fwd();
        test_pc();
        test_back_to_back();
        test_reset_discard();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/alu_writeback.md
Name: alu_writeback

Overview:
- Retire stage directly downstream of the ALU op units (OR/AND/ADD, etc.).
- Accepts each result (Rd value, destination index, NZCV flags plus update enables) and buffers it in a 2-entry FIFO.
- Retires the head entry into the 16x32 architectural register file and the APSR NZCV register.
- Provides a bypassed read port and forwarded flags, so the next ALU op sees up-to-date operands and carry_in/zero_in/neg_in.

Parameters:
DATA_W, 32, width of result and register data
NREG, 16, number of architectural registers (r0..r15)
AW, 4, register index width
DEPTH, 2, pending-result FIFO depth (fixed at 2, not to be changed)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  ALU result present this cycle
in_ready  output  1  stage can accept a result this cycle
in_rd_idx  input  AW  destination register index
in_rd_data  input  DATA_W  ALU result Rd
in_wr_en  input  1  result writes Rd (0 for TST/CMP-style ops)
in_flag_en  input  1  S bit: flags below update APSR
in_n / in_z / in_c / in_v  input  1 each  ALU flag outputs
wb_stall  input  1  hold retirement this cycle
rd_a_idx  input  AW  read port index
rd_a_data  output  DATA_W  bypassed register value
nzcv_arch  output  4  retired APSR flags {N,Z,C,V}
nzcv_fwd  output  4  youngest flags incl. pending entries
pc_load  output  1  one-cycle pulse: r15 written at retire
pc_value  output  DATA_W  value for pc_load
pending  output  2  FIFO occupancy (0..2)

Behaviour:
- Reset values (rst sampled high at posedge):
  - FIFO emptied, pending=0, in_ready=1.
  - nzcv_arch=4'b0000, pc_load=0, pc_value=0.
  - All r0..r14 cleared to 0.
  - In-flight entries are discarded and never retire. rst has priority over all other inputs.
- Accept:
  - Push when in_valid & in_ready.
  - in_ready = (pending != 2). It depends only on registered occupancy, not on a same-cycle pop.
  - in_valid while in_ready=0 is ignored; the source holds its inputs.
- Retire:
  - Head pops at posedge when pending != 0 and wb_stall=0. One retire per cycle max. Latency from accept to architectural update is 1 cycle minimum.
  - Retire effects:
    - wr_en=1 and idx<15: rf[idx] <= data.
    - wr_en=1 and idx==15: pc_load=1 and pc_value=data for exactly the cycle after retire; rf is not written.
    - flag_en=1: nzcv_arch <= entry flags.
  - An entry with wr_en=0 and flag_en=0 still occupies a slot and retires with no effect.
- Simultaneous push and pop: occupancy is unchanged and FIFO order is preserved. With pending=1, push+pop makes the new entry the head.
- Bypass (combinational), rd_a_data priority:
  1. Youngest pending entry with wr_en=1 and idx==rd_a_idx.
  2. Older pending entry with wr_en=1 and idx==rd_a_idx.
  3. rf[rd_a_idx].
  - rd_a_idx==15 returns pc_value.
  - The incoming in_* result is not bypassed.
- nzcv_fwd: flags of the youngest pending entry with flag_en=1, else nzcv_arch.
- wb_stall held any number of cycles:
  - No state changes except pushes.
  - Once pending=2, in_ready stays 0 until the first unstalled cycle.

Test Plan:
- Reset then push idx=3, data=0x0000_00F0, wr_en=1, flag_en=1, NZCV=0100, no stall:
  - Cycle after accept: rf[3]=0x0000_00F0, nzcv_arch=4'b0100, pending=0.
- wb_stall=1, push idx=1 data=0xAAAA_0000, then idx=1 data=0x5555_0000:
  - pending=2, in_ready=0.
  - rd_a_idx=1 reads 0x5555_0000.
  - A third push is ignored.
  - Release stall: two retires on consecutive cycles, final rf[1]=0x5555_0000.
- Flag forwarding: entry A flag_en=1 NZCV=1000, entry B flag_en=0, stall held:
  - nzcv_fwd=1000 while nzcv_arch still shows the old value.
  - After both retire, nzcv_arch=1000.
- Push idx=15 data=0x0000_0100 wr_en=1:
  - pc_load pulses 1 cycle with pc_value=0x0000_0100.
  - rf[0..14] unchanged.
- pending=1 with stall=0 and a push in the same cycle:
  - pending stays 1, head retired, new entry retires the next cycle, in_ready stays 1 throughout.
- rst asserted with pending=2 under stall:
  - Next cycle pending=0, nzcv_arch=0, rd_a_data=0 for every idx.
  - The discarded entries never retire.
